vend_select_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for product-select requests in the vending machine.

---
 rtl/vend_select_arbiter.sv | 119 +++++++++++
 tb/tb_vend_select_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_select_arbiter.sv
// Round-robin product-select arbiter for the vending machine.
// Latches keypad requests, masks sold-out items and offers one index at a time.
module vend_select_arbiter #(
  parameter int N            = 2,
  parameter int COOLDOWN_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2**N-1:0]   req_in,
  input  logic [2**N-1:0]   req_mask,
  output logic              grant_valid,
  output logic [N-1:0]      grant_idx,
  input  logic              grant_ready,
  input  logic              done,
  output logic              busy,
  output logic [2**N-1:0]   pending
);

  localparam int NUM = 2**N;
  localparam int CW  = (COOLDOWN_CYC > 0) ? $clog2(COOLDOWN_CYC + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    BUSY,
    COOL
  } state_t;

  state_t          state;
  logic [N-1:0]    last_grant;
  logic [CW-1:0]   cnt;
  logic [NUM-1:0]  clr;
  logic [N-1:0]    pick;
  logic            have_pick;
  logic            accept;

  assign accept      = (state == OFFER) && grant_ready;
  assign grant_valid = (state == OFFER);
  assign busy        = (state != IDLE);

  // One-hot clear of the offered item on the handshake cycle
  always_comb begin
    clr = '0;
    if (accept) begin
      clr[grant_idx] = 1'b1;
    end
  end

  // First pending item after the last grant, wrapping around
  always_comb begin
    logic [N-1:0] idx;
    pick      = '0;
    have_pick = 1'b0;
    idx       = '0;
    for (int i = 1; i <= NUM; i++) begin
      idx = last_grant + N'(i);
      if (!have_pick && pending[idx]) begin
        have_pick = 1'b1;
        pick      = idx;
      end
    end
  end

  // Request latch: fresh press re-arms an accepted item, sold-out wins
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= ((pending & ~clr) | req_in) & ~req_mask;
    end
  end

  // Offer / dispense / cooldown sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_idx  <= '0;
      last_grant <= N'(NUM - 1);
      cnt        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (have_pick) begin
            state     <= OFFER;
            grant_idx <= pick;
          end
        end
        OFFER: begin
          if (grant_ready) begin
            last_grant <= grant_idx;
            state      <= BUSY;
          end else if (req_mask[grant_idx]) begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (done) begin
            if (COOLDOWN_CYC == 0) begin
              state <= IDLE;
            end else begin
              state <= COOL;
              cnt   <= CW'(COOLDOWN_CYC);
            end
          end
        end
        COOL: begin
          if (cnt == CW'(1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_select_arbiter.sv
// Bench for vend_select_arbiter: two builds (cooldown 4 and 0) against
// a behavioural model, directed scenarios plus random traffic.
module tb_vend_select_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_in;
  logic [3:0] req_mask;
  logic       grant_ready;
  logic       done;

  logic       gv0, gv1, busy0, busy1;
  logic [1:0] gi0, gi1;
  logic [3:0] pend0, pend1;

  vend_select_arbiter #(.N(2), .COOLDOWN_CYC(4)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .req_mask(req_mask),
    .grant_valid(gv0), .grant_idx(gi0), .grant_ready(grant_ready),
    .done(done), .busy(busy0), .pending(pend0)
  );

  vend_select_arbiter #(.N(2), .COOLDOWN_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .req_in(req_in), .req_mask(req_mask),
    .grant_valid(gv1), .grant_idx(gi1), .grant_ready(grant_ready),
    .done(done), .busy(busy1), .pending(pend1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // model: 0 idle, 1 offering, 2 dispensing, 3 cooling
  int         m_st[2];
  logic [3:0] m_pend[2];
  int         m_last[2];
  int         m_idx[2];
  int         m_left[2];
  int         cd[2] = '{4, 0};
  int         acc_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int u, input bit r, input logic [3:0] rq,
                            input logic [3:0] mk, input bit rdy, input bit dn);
    logic [3:0] p0;
    logic [3:0] np;
    bit         acc;
    bit         found;
    int         k;
    p0    = m_pend[u];
    np    = '0;
    found = 0;
    if (r) begin
      m_st[u]   = 0;
      m_pend[u] = '0;
      m_last[u] = 3;
      m_idx[u]  = 0;
      m_left[u] = 0;
      return;
    end
    acc = (m_st[u] == 1) && rdy;
    for (int i = 0; i < 4; i++) begin
      np[i] = ((p0[i] && !(acc && i == m_idx[u])) || rq[i]) && !mk[i];
    end
    case (m_st[u])
      0: begin
        for (int j = 1; j <= 4; j++) begin
          k = (m_last[u] + j) % 4;
          if (!found && p0[k]) begin
            found    = 1;
            m_idx[u] = k;
            m_st[u]  = 1;
          end
        end
      end
      1: begin
        if (rdy) begin
          m_last[u] = m_idx[u];
          m_st[u]   = 2;
        end else if (mk[m_idx[u]]) begin
          m_st[u] = 0;
        end
      end
      2: begin
        if (dn) begin
          if (cd[u] == 0) m_st[u] = 0;
          else begin
            m_st[u]   = 3;
            m_left[u] = cd[u];
          end
        end
      end
      default: begin
        m_left[u]--;
        if (m_left[u] == 0) m_st[u] = 0;
      end
    endcase
    m_pend[u] = np;
  endtask

  task automatic compare_all();
    chk("gv0", int'(gv0), int'(m_st[0] == 1));
    chk("busy0", int'(busy0), int'(m_st[0] != 0));
    chk("pend0", int'(pend0), int'(m_pend[0]));
    chk("idx0", int'(gi0), m_idx[0]);
    chk("gv1", int'(gv1), int'(m_st[1] == 1));
    chk("busy1", int'(busy1), int'(m_st[1] != 0));
    chk("pend1", int'(pend1), int'(m_pend[1]));
    chk("idx1", int'(gi1), m_idx[1]);
  endtask

  // one clock: drive, step the model at the edge, compare just after
  task automatic cyc(input logic [3:0] rq, input logic [3:0] mk,
                     input bit rdy, input bit dn, input bit r);
    rst         = r;
    req_in      = rq;
    req_mask    = mk;
    grant_ready = rdy;
    done        = dn;
    if (!r && m_st[0] == 1 && rdy) acc_q.push_back(m_idx[0]);
    @(posedge clk);
    model_step(0, r, rq, mk, rdy, dn);
    model_step(1, r, rq, mk, rdy, dn);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  function automatic int q_at(input int i);
    if (i < acc_q.size()) return acc_q[i];
    return -1;
  endfunction

  initial begin
    rst = 1; req_in = 0; req_mask = 0; grant_ready = 0; done = 0;
    for (int u = 0; u < 2; u++) begin
      m_st[u] = 0; m_pend[u] = 0; m_last[u] = 3; m_idx[u] = 0; m_left[u] = 0;
    end

    // single request, full offer/dispense/cooldown cycle
    cyc(0, 0, 0, 0, 1);
    chk("rst_gv", int'(gv0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_pend", int'(pend0), 0);
    chk("rst_idx", int'(gi0), 0);
    cyc(4'b0100, 0, 0, 0, 0);
    chk("s1_latch", int'(pend0), 4);
    chk("s1_nogv", int'(gv0), 0);
    cyc(0, 0, 0, 0, 0);
    chk("s1_gv", int'(gv0), 1);
    chk("s1_idx", int'(gi0), 2);
    cyc(0, 0, 1, 0, 0);
    chk("s1_busy", int'(busy0), 1);
    chk("s1_clr", int'(pend0), 0);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("s1_cool", int'(busy0), 1);
    end
    cyc(0, 0, 0, 0, 0);
    chk("s1_idle", int'(busy0), 0);

    // all four at once, ready tied high: rotation 0,1,2,3 then wrap
    cyc(0, 0, 0, 0, 1);
    acc_q.delete();
    cyc(4'b1111, 0, 1, 0, 0);
    for (int i = 0; i < 40; i++) cyc(0, 0, 1, m_st[0] == 2, 0);
    cyc(4'b0001, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, m_st[0] == 2, 0);
    for (int i = 0; i < 4; i++) chk("s2_order", q_at(i), i);
    chk("s2_wrap", q_at(4), 0);

    // withdraw on sold-out, and accept beats mask
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, m_st[0] == 2, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(4'b0010, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("s3_offer", int'(gi0), 1);
    cyc(0, 4'b0010, 0, 0, 0);
    chk("s3_drop", int'(gv0), 0);
    chk("s3_idle", int'(busy0), 0);
    chk("s3_pend", int'(pend0), 0);
    cyc(4'b0010, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    acc_q.delete();
    cyc(0, 4'b0010, 1, 0, 0);
    chk("s3_acc", int'(busy0), 1);
    chk("s3_accidx", q_at(0), 1);

    // re-press during accept keeps bit; RR puts 0 ahead of 3
    cyc(0, 0, 0, 0, 1);
    cyc(4'b1000, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("s4_offer", int'(gi0), 3);
    cyc(4'b1000, 0, 1, 0, 0);
    chk("s4_keep", int'(pend0), 8);
    cyc(4'b0001, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
    chk("s4_rr", int'(gi0), 0);
    chk("s4_rrv", int'(gv0), 1);

    // reset mid-dispense
    cyc(0, 0, 0, 0, 1);
    cyc(4'b0001, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(4'b0100, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("s5_busy", int'(busy0), 0);
    chk("s5_pend", int'(pend0), 0);
    chk("s5_gv", int'(gv0), 0);
    cyc(0, 0, 0, 1, 0);
    chk("s5_done", int'(busy0), 0);

    // zero-cooldown build: done -> idle, offer on the following edge
    cyc(0, 0, 0, 0, 1);
    cyc(4'b0001, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(4'b0010, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("s6_idle", int'(busy1), 0);
    cyc(0, 0, 0, 0, 0);
    chk("s6_gv", int'(gv1), 1);
    chk("s6_idx", int'(gi1), 1);

    // random traffic
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] rq;
      logic [3:0] mk;
      rq = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      mk = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      cyc(rq, mk, 1'($urandom), $urandom_range(0, 3) == 0,
          $urandom_range(0, 299) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
